// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART state encoding, default frame constants and counter sizing helper
package uart_pkg;

  localparam int NB_DATA      = 8;
  localparam int N_OVERSAMPLE = 16;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_t;

  // Width of a counter that must reach max(a, b) - 1.
  function automatic int cnt_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m <= 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// rtl/uart_rx_if.sv - receiver byte output bundle; UART_RX_PARITY_EN adds o_parity_err
interface uart_rx_if #(
  parameter int NB_DATA = uart_pkg::NB_DATA
);

  logic [NB_DATA-1:0] o_data;
  logic               o_rx_done;
  logic               o_frame_err;
`ifdef UART_RX_PARITY_EN
  logic               o_parity_err;

  modport master (output o_data, o_rx_done, o_frame_err, o_parity_err);
  modport slave  (input  o_data, o_rx_done, o_frame_err, o_parity_err);
`else
  modport master (output o_data, o_rx_done, o_frame_err);
  modport slave  (input  o_data, o_rx_done, o_frame_err);
`endif

endinterface

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchronizer with asynchronous active-high reset to RESET_VAL
module sync_2ff #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_meta <= RESET_VAL;
      r_sync <= RESET_VAL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 16x oversampling UART receiver, 8N1; UART_RX_PARITY_EN adds an even-parity bit
module uart_rx #(
  parameter int NB_DATA      = uart_pkg::NB_DATA,
  parameter int N_STOP_TICKS = 16,
  parameter int N_OVERSAMPLE = uart_pkg::N_OVERSAMPLE
) (
  input  logic      i_clk,
  input  logic      i_reset,
  input  logic      i_tick,
  input  logic      i_rx,
  uart_rx_if.master rx_if
);

  import uart_pkg::*;

  localparam int SW = cnt_width(N_OVERSAMPLE, N_STOP_TICKS);
  localparam int NW = (NB_DATA > 1) ? $clog2(NB_DATA) : 1;

  localparam logic [SW-1:0] S_MID  = SW'(N_OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] S_BIT  = SW'(N_OVERSAMPLE - 1);
  localparam logic [SW-1:0] S_STOP = SW'(N_STOP_TICKS - 1);
  localparam logic [NW-1:0] N_LAST = NW'(NB_DATA - 1);

  logic               w_rx_s;
  uart_state_t        r_state,     w_state;
  logic [SW-1:0]      r_s,         w_s;
  logic [NW-1:0]      r_n,         w_n;
  logic [NB_DATA-1:0] r_sh,        w_sh;
  logic [NB_DATA-1:0] r_data,      w_data;
  logic               r_rx_done,   w_rx_done;
  logic               r_frame_err, w_frame_err;
`ifdef UART_RX_PARITY_EN
  logic               r_par_bit,    w_par_bit;
  logic               r_parity_err, w_parity_err;
`endif

  sync_2ff #(.RESET_VAL(1'b1)) u_sync (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_d     (i_rx),
    .o_q     (w_rx_s)
  );

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state     <= ST_IDLE;
      r_s         <= '0;
      r_n         <= '0;
      r_sh        <= '0;
      r_data      <= '0;
      r_rx_done   <= 1'b0;
      r_frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_par_bit    <= 1'b0;
      r_parity_err <= 1'b0;
`endif
    end else begin
      r_state     <= w_state;
      r_s         <= w_s;
      r_n         <= w_n;
      r_sh        <= w_sh;
      r_data      <= w_data;
      r_rx_done   <= w_rx_done;
      r_frame_err <= w_frame_err;
`ifdef UART_RX_PARITY_EN
      r_par_bit    <= w_par_bit;
      r_parity_err <= w_parity_err;
`endif
    end
  end

  always_comb begin
    w_state     = r_state;
    w_s         = r_s;
    w_n         = r_n;
    w_sh        = r_sh;
    w_data      = r_data;
    w_rx_done   = 1'b0;
    w_frame_err = 1'b0;
`ifdef UART_RX_PARITY_EN
    w_par_bit    = r_par_bit;
    w_parity_err = 1'b0;
`endif
    case (r_state)
      // Leaving IDLE clears s, so a tick landing on this cycle is not counted.
      ST_IDLE: begin
        if (!w_rx_s) begin
          w_state = ST_START;
          w_s     = '0;
        end
      end
      ST_START: begin
        if (i_tick) begin
          if (r_s == S_MID) begin
            if (!w_rx_s) begin
              w_state = ST_DATA;
              w_s     = '0;
              w_n     = '0;
            end else begin
              w_state = ST_IDLE;
            end
          end else begin
            w_s = r_s + 1'b1;
          end
        end
      end
      ST_DATA: begin
        if (i_tick) begin
          if (r_s == S_BIT) begin
            w_s  = '0;
            w_sh = {w_rx_s, r_sh[NB_DATA-1:1]};
            if (r_n == N_LAST) begin
`ifdef UART_RX_PARITY_EN
              w_state = ST_PARITY;
`else
              w_state = ST_STOP;
`endif
            end else begin
              w_n = r_n + 1'b1;
            end
          end else begin
            w_s = r_s + 1'b1;
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        if (i_tick) begin
          if (r_s == S_BIT) begin
            w_par_bit = w_rx_s;
            w_s       = '0;
            w_state   = ST_STOP;
          end else begin
            w_s = r_s + 1'b1;
          end
        end
      end
`endif
      // Returning to IDLE mid stop bit lets a back-to-back start edge be caught.
      ST_STOP: begin
        if (i_tick) begin
          if (r_s == S_STOP) begin
            w_state = ST_IDLE;
            if (w_rx_s) begin
              w_data    = r_sh;
              w_rx_done = 1'b1;
`ifdef UART_RX_PARITY_EN
              w_parity_err = ^{r_sh, r_par_bit};
`endif
            end else begin
              w_frame_err = 1'b1;
            end
          end else begin
            w_s = r_s + 1'b1;
          end
        end
      end
      default: w_state = ST_IDLE;
    endcase
  end

  assign rx_if.o_data      = r_data;
  assign rx_if.o_rx_done   = r_rx_done;
  assign rx_if.o_frame_err = r_frame_err;
`ifdef UART_RX_PARITY_EN
  assign rx_if.o_parity_err = r_parity_err;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - directed bench for uart_rx; parity steps run when UART_RX_PARITY_EN is defined
module tb_uart_rx;

  localparam int BIT_CYC = 64;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick = 1'b0;
  logic       rx = 1'b1;
  logic [1:0] tick_cnt = 2'd0;

  int tests = 0;
  int fails = 0;
  int n_done = 0;
  int n_ferr = 0;
  int n_both = 0;
  int n_long = 0;
  int n_perr = 0;
  logic [7:0] cap [0:31];
  logic prev_done = 1'b0;
  logic prev_ferr = 1'b0;

  uart_rx_if #(.NB_DATA(8)) rx_if ();

  uart_rx #(.NB_DATA(8), .N_STOP_TICKS(16), .N_OVERSAMPLE(16)) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .i_tick  (tick),
    .i_rx    (rx),
    .rx_if   (rx_if)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    tick_cnt <= tick_cnt + 2'd1;
    tick     <= (tick_cnt == 2'd2);
  end

  always @(negedge clk) begin
    prev_done <= rx_if.o_rx_done;
    prev_ferr <= rx_if.o_frame_err;
    if (rx_if.o_rx_done) begin
      n_done      <= n_done + 1;
      cap[n_done] <= rx_if.o_data;
    end
    if (rx_if.o_frame_err) n_ferr <= n_ferr + 1;
    if (rx_if.o_rx_done && rx_if.o_frame_err) n_both <= n_both + 1;
    if ((prev_done && rx_if.o_rx_done) || (prev_ferr && rx_if.o_frame_err)) n_long <= n_long + 1;
`ifdef UART_RX_PARITY_EN
    if (rx_if.o_parity_err && !rx_if.o_rx_done) n_long <= n_long + 1;
    if (rx_if.o_parity_err) n_perr <= n_perr + 1;
`endif
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_bit(input logic v, input int cyc);
    rx = v;
    repeat (cyc) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_ok);
    drive_bit(1'b0, BIT_CYC);
    for (int i = 0; i < 8; i++) drive_bit(d[i], BIT_CYC);
    if (stop_ok) begin
      drive_bit(1'b1, BIT_CYC);
    end else begin
      drive_bit(1'b0, 48);
      drive_bit(1'b1, 16);
    end
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic send_frame_par(input logic [7:0] d, input logic p);
    drive_bit(1'b0, BIT_CYC);
    for (int i = 0; i < 8; i++) drive_bit(d[i], BIT_CYC);
    drive_bit(p, BIT_CYC);
    drive_bit(1'b1, BIT_CYC);
  endtask
`endif

  initial begin
    logic [7:0] partial;
    partial = 8'h5A;
    rx  = 1'b1;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_data", {24'd0, rx_if.o_data}, 32'h0);
    check("reset_done", {31'd0, rx_if.o_rx_done}, 32'h0);
    check("reset_ferr", {31'd0, rx_if.o_frame_err}, 32'h0);
    rst = 1'b0;
    drive_bit(1'b1, 40);

    send_frame(8'h55, 1'b1);
    drive_bit(1'b1, 20);
    check("t1_done_cnt", n_done, 1);
    check("t1_cap", {24'd0, cap[0]}, 32'h55);
    check("t1_data", {24'd0, rx_if.o_data}, 32'h55);
    check("t1_ferr_cnt", n_ferr, 0);

    send_frame(8'hA5, 1'b1);
    send_frame(8'h3C, 1'b1);
    drive_bit(1'b1, 20);
    check("t2_done_cnt", n_done, 3);
    check("t2_cap0", {24'd0, cap[1]}, 32'hA5);
    check("t2_cap1", {24'd0, cap[2]}, 32'h3C);
    check("t2_data", {24'd0, rx_if.o_data}, 32'h3C);

    drive_bit(1'b0, 20);
    drive_bit(1'b1, 100);
    check("t3_done_cnt", n_done, 3);
    check("t3_ferr_cnt", n_ferr, 0);
    check("t3_data", {24'd0, rx_if.o_data}, 32'h3C);
    send_frame(8'h96, 1'b1);
    drive_bit(1'b1, 20);
    check("t3_after_cnt", n_done, 4);
    check("t3_after_cap", {24'd0, cap[3]}, 32'h96);

    send_frame(8'h7E, 1'b0);
    drive_bit(1'b1, 100);
    check("t4_ferr_cnt", n_ferr, 1);
    check("t4_done_cnt", n_done, 4);
    check("t4_data", {24'd0, rx_if.o_data}, 32'h96);

    drive_bit(1'b0, BIT_CYC);
    for (int i = 0; i < 4; i++) drive_bit(partial[i], BIT_CYC);
    drive_bit(partial[4], 30);
    rst = 1'b1;
    @(negedge clk);
    check("t5_rst_data", {24'd0, rx_if.o_data}, 32'h0);
    check("t5_rst_done", {31'd0, rx_if.o_rx_done}, 32'h0);
    check("t5_rst_ferr", {31'd0, rx_if.o_frame_err}, 32'h0);
    repeat (4) @(negedge clk);
    rst = 1'b0;
    drive_bit(1'b1, 100);
    check("t5_no_pulse", n_done, 4);
    send_frame(8'h81, 1'b1);
    drive_bit(1'b1, 20);
    check("t5_done_cnt", n_done, 5);
    check("t5_cap", {24'd0, cap[4]}, 32'h81);
    check("t5_data", {24'd0, rx_if.o_data}, 32'h81);

`ifdef UART_RX_PARITY_EN
    send_frame_par(8'h03, 1'b1);
    drive_bit(1'b1, 20);
    check("t6_done_cnt_bad", n_done, 6);
    check("t6_perr_cnt_bad", n_perr, 1);
    check("t6_cap_bad", {24'd0, cap[5]}, 32'h03);
    send_frame_par(8'h03, 1'b0);
    drive_bit(1'b1, 20);
    check("t6_done_cnt_ok", n_done, 7);
    check("t6_perr_cnt_ok", n_perr, 1);
    check("t6_data_ok", {24'd0, rx_if.o_data}, 32'h03);
`endif

    check("both_pulses", n_both, 0);
    check("long_pulses", n_long, 0);
    check("final_ferr_cnt", n_ferr, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
